// File: rtl/spad_req_dispatch.sv
// spad_req_dispatch: request FIFO plus dispatcher that drives scratchpad load/store and GEMM command ports
module spad_req_dispatch #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 38,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               fifo_wen,
    input  logic [ENTRY_W-1:0] fifo_wdata,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               ld_req,
    output logic [31:0]        ld_addr,
    output logic [3:0]         ld_matrix,
    input  logic               ld_done,
    output logic               st_req,
    output logic [31:0]        st_addr,
    output logic [3:0]         st_matrix,
    input  logic               st_done,
    output logic               gemm_valid,
    input  logic               gemm_ready,
    output logic               gemm_new_weight,
    output logic [3:0]         gemm_rs1,
    output logic [3:0]         gemm_rs2,
    output logic [3:0]         gemm_rs3,
    output logic [3:0]         gemm_rd,
    output logic               mls_complete,
    output logic [3:0]         mls_complete_matrix,
    output logic               bad_op,
    output logic               overflow
);
    localparam int AW = $clog2(DEPTH);

    // state values deliberately match the op field so decode is a direct cast
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, STORE = 2'b10, GEMM = 2'b11} state_t;

    state_t             state, state_nx;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rptr, wptr;
    logic [CNT_W-1:0]   count, count_nx;
    logic [ENTRY_W-1:0] head;
    logic [1:0]         op;
    logic               push, pop, ld_fin, st_fin;

    assign head       = mem[rptr];
    assign op         = head[37:36];
    assign push       = fifo_wen && !fifo_full;
    assign pop        = state == IDLE && count != '0;
    assign count_nx   = count + CNT_W'(push) - CNT_W'(pop);
    assign ld_fin     = state == LOAD && ld_done;
    assign st_fin     = state == STORE && st_done;
    assign fifo_count = count;
    assign ld_req     = state == LOAD;
    assign st_req     = state == STORE;
    assign gemm_valid = state == GEMM;

    // next-state: pop decodes head op, each busy state waits for its own handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pop ? state_t'(op) : IDLE;
            LOAD:    state_nx = ld_done ? IDLE : LOAD;
            STORE:   state_nx = st_done ? IDLE : STORE;
            default: state_nx = gemm_ready ? IDLE : GEMM;
        endcase
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // storage array needs no reset; only pointers and count define validity
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= fifo_wdata;
    end

    // fifo pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rptr      <= rptr + AW'(pop);
            wptr      <= wptr + AW'(push);
            count     <= count_nx;
            fifo_full <= count_nx == CNT_W'(DEPTH);
            overflow  <= overflow || (fifo_wen && fifo_full);
        end
    end

    // latch decoded fields at pop and hold them until the next request of the same kind
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_addr         <= '0;
            ld_matrix       <= '0;
            st_addr         <= '0;
            st_matrix       <= '0;
            gemm_new_weight <= 1'b0;
            gemm_rs1        <= '0;
            gemm_rs2        <= '0;
            gemm_rs3        <= '0;
            gemm_rd         <= '0;
        end else if (pop) begin
            if (op == 2'b01) begin
                ld_addr   <= head[31:0];
                ld_matrix <= head[35:32];
            end
            if (op == 2'b10) begin
                st_addr   <= head[31:0];
                st_matrix <= head[35:32];
            end
            if (op == 2'b11) begin
                gemm_new_weight <= head[35];
                gemm_rs1        <= head[15:12];
                gemm_rs2        <= head[11:8];
                gemm_rs3        <= head[7:4];
                gemm_rd         <= head[3:0];
            end
        end
    end

    // single-cycle completion and bad-op pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mls_complete        <= 1'b0;
            mls_complete_matrix <= '0;
            bad_op              <= 1'b0;
        end else begin
            mls_complete        <= ld_fin || st_fin;
            mls_complete_matrix <= ld_fin ? ld_matrix : st_fin ? st_matrix : mls_complete_matrix;
            bad_op              <= pop && op == 2'b00;
        end
    end
endmodule

// File: tb/tb_spad_req_dispatch.sv
// tb_spad_req_dispatch: directed test-plan sequences plus random traffic against a queue-based model
module tb_spad_req_dispatch;
    localparam int DEPTH = 8;

    logic        CLK = 0, RST = 0;
    logic        fifo_wen = 0, ld_done = 0, st_done = 0, gemm_ready = 0;
    logic [37:0] fifo_wdata = '0;
    logic        fifo_full, ld_req, st_req, gemm_valid, gemm_new_weight;
    logic        mls_complete, bad_op, overflow;
    logic [3:0]  fifo_count;
    logic [31:0] ld_addr, st_addr;
    logic [3:0]  ld_matrix, st_matrix, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd, mls_complete_matrix;

    spad_req_dispatch dut (
        .CLK(CLK), .RST(RST), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_matrix(ld_matrix), .ld_done(ld_done),
        .st_req(st_req), .st_addr(st_addr), .st_matrix(st_matrix), .st_done(st_done),
        .gemm_valid(gemm_valid), .gemm_ready(gemm_ready), .gemm_new_weight(gemm_new_weight),
        .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3), .gemm_rd(gemm_rd),
        .mls_complete(mls_complete), .mls_complete_matrix(mls_complete_matrix),
        .bad_op(bad_op), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // reference model: queue of pending entries plus the request currently in service (0 = none)
    logic [37:0] m_q[$];
    logic [1:0]  m_busy;
    logic [31:0] m_ld_addr, m_st_addr;
    logic [3:0]  m_ld_m, m_st_m, m_rs1, m_rs2, m_rs3, m_rd, m_mlsm;
    logic        m_nw, m_mls, m_bad, m_ovf;

    task automatic m_reset();
        m_q.delete();
        m_busy = 0; m_ld_addr = 0; m_st_addr = 0; m_ld_m = 0; m_st_m = 0;
        m_rs1 = 0; m_rs2 = 0; m_rs3 = 0; m_rd = 0; m_nw = 0;
        m_mlsm = 0; m_mls = 0; m_bad = 0; m_ovf = 0;
    endtask

    task automatic m_step();
        logic [37:0] e;
        bit was_full = m_q.size() == DEPTH;
        bit take = m_busy == 0 && m_q.size() != 0;
        m_mls = 0;
        m_bad = 0;
        if (m_busy == 1 && ld_done) begin m_mls = 1; m_mlsm = m_ld_m; m_busy = 0; end
        else if (m_busy == 2 && st_done) begin m_mls = 1; m_mlsm = m_st_m; m_busy = 0; end
        else if (m_busy == 3 && gemm_ready) m_busy = 0;
        if (take) begin
            e = m_q.pop_front();
            m_busy = e[37:36];
            if (e[37:36] == 0) m_bad = 1;
            if (e[37:36] == 1) begin m_ld_addr = e[31:0]; m_ld_m = e[35:32]; end
            if (e[37:36] == 2) begin m_st_addr = e[31:0]; m_st_m = e[35:32]; end
            if (e[37:36] == 3) begin
                m_nw = e[35]; m_rs1 = e[15:12]; m_rs2 = e[11:8]; m_rs3 = e[7:4]; m_rd = e[3:0];
            end
        end
        if (fifo_wen) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(fifo_wdata);
        end
    endtask

    task automatic check_all();
        check("full", fifo_full, m_q.size() == DEPTH);
        check("count", fifo_count, m_q.size());
        check("ld_req", ld_req, m_busy == 1);
        check("st_req", st_req, m_busy == 2);
        check("gemm_valid", gemm_valid, m_busy == 3);
        check("ld_addr", ld_addr, m_ld_addr);
        check("ld_matrix", ld_matrix, m_ld_m);
        check("st_addr", st_addr, m_st_addr);
        check("st_matrix", st_matrix, m_st_m);
        check("new_weight", gemm_new_weight, m_nw);
        check("rs", {gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd}, {m_rs1, m_rs2, m_rs3, m_rd});
        check("mls", mls_complete, m_mls);
        check("mls_matrix", mls_complete_matrix, m_mlsm);
        check("bad_op", bad_op, m_bad);
        check("overflow", overflow, m_ovf);
    endtask

    // one clock: drive at negedge, step model at posedge, compare 1 time unit later
    task automatic cyc(input logic w, input logic [37:0] d, input logic ld, input logic sd, input logic gr);
        fifo_wen = w; fifo_wdata = d; ld_done = ld; st_done = sd; gemm_ready = gr;
        @(posedge CLK);
        m_step();
        #1 check_all();
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic ld, input logic sd, input logic gr);
        for (int i = 0; i < n; i++) cyc(0, '0, ld, sd, gr);
    endtask

    task automatic hit_reset();
        RST = 1;
        #1 m_reset();
        check_all();
        check("rst_count", fifo_count, 0);
        check("rst_streq", st_req, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [37:0] rd;
        m_reset();
        @(negedge CLK);
        hit_reset();

        cyc(1, {2'b01, 4'h3, 32'h0000_1000}, 0, 0, 0);
        check("tp1_noreq", ld_req, 0);
        idle(1, 0, 0, 0);
        check("tp1_ldreq", ld_req, 1);
        check("tp1_addr", ld_addr, 32'h0000_1000);
        check("tp1_mat", ld_matrix, 3);
        cyc(0, '0, 1, 0, 0);
        check("tp1_mls", mls_complete, 1);
        check("tp1_mlsm", mls_complete_matrix, 3);
        check("tp1_ldreq0", ld_req, 0);
        idle(1, 0, 0, 0);
        check("tp1_pulse", mls_complete, 0);

        cyc(1, {2'b10, 4'h5, 32'hDEAD_BEE0}, 0, 0, 0);
        cyc(1, {2'b11, 4'b1000, 16'h0, 16'h1234}, 0, 0, 0);
        check("tp2_streq", st_req, 1);
        check("tp2_staddr", st_addr, 32'hDEAD_BEE0);
        cyc(0, '0, 0, 1, 0);
        check("tp2_mlsm", mls_complete_matrix, 5);
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, 0, 0);
            check("tp2_gv", gemm_valid, 1);
            check("tp2_rs", {gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd}, {1'b1, 16'h1234});
        end
        cyc(0, '0, 0, 0, 1);
        check("tp2_gv0", gemm_valid, 0);
        check("tp2_nomls", mls_complete, 0);

        cyc(1, {2'b01, 4'h7, 32'h7000}, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, {2'b01, 4'(i), 32'h100 + 32'(i)}, 0, 0, 0);
        check("tp3_full", fifo_full, 1);
        check("tp3_count", fifo_count, 8);
        check("tp3_ovf", overflow, 1);
        cyc(0, '0, 1, 0, 0);
        cyc(1, {2'b01, 4'hE, 32'hEEEE}, 0, 0, 0);
        check("tp4_rej", fifo_count, 7);
        cyc(1, {2'b01, 4'hF, 32'hFFFF}, 0, 0, 0);
        check("tp4_acc", fifo_count, 8);
        for (int i = 0; i < 40; i++)
            cyc(i < 16, {2'b01, 4'(i), 32'h2000 + 32'(i)}, 1, 0, 0);
        check("tp4_ovf_sticky", overflow, 1);
        check("tp4_empty", fifo_count, 0);

        cyc(1, {2'b00, 4'h9, 32'h9}, 0, 0, 0);
        cyc(1, {2'b01, 4'hA, 32'hA0}, 0, 0, 0);
        check("tp5_bad", bad_op, 1);
        cyc(0, '0, 0, 0, 0);
        check("tp5_bad0", bad_op, 0);
        check("tp5_ldreq", ld_req, 1);
        check("tp5_ldm", ld_matrix, 4'hA);
        cyc(0, '0, 1, 0, 0);
        check("tp5_mls", mls_complete, 1);

        for (int i = 0; i < 5; i++) cyc(1, {2'b10, 4'(i), 32'h3000 + 32'(i)}, 0, 0, 0);
        check("tp6_streq", st_req, 1);
        check("tp6_cnt", fifo_count, 4);
        #2 hit_reset();
        cyc(0, '0, 0, 1, 0);
        check("tp6_nomls", mls_complete, 0);
        check("tp6_ovf", overflow, 0);

        for (int i = 0; i < 3000; i++) begin
            rop = 2'($urandom_range(3));
            rd = {rop, 4'($urandom), 32'($urandom)};
            cyc($urandom_range(99) < 55, rd, $urandom_range(99) < 35,
                $urandom_range(99) < 35, $urandom_range(99) < 35);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spad_req_dispatch.md
Name: spad_req_dispatch

Overview:
- Consumer end of the execute-to-scratchpad request FIFO.
- Execute pushes packed matrix load/store and GEMM requests.
- This block buffers them, decodes the head entry, and drives the scratchpad load, store and GEMM command ports one request at a time with handshakes.
- Returns a per-request completion pulse to the matrix load/store path.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- ENTRY_W, 38, packed request width: [37:36] op, [35:32] matrix/flags, [31:0] address or GEMM payload
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous active-high reset
- fifo_wen  input  1  push request from execute
- fifo_wdata  input  ENTRY_W  packed request
- fifo_full  output  1  FIFO cannot accept a push this cycle
- fifo_count  output  CNT_W  current occupancy
- ld_req  output  1  scratchpad load request, held until ld_done
- ld_addr  output  32  load base address
- ld_matrix  output  4  destination matrix register
- ld_done  input  1  load finished (single-cycle pulse)
- st_req  output  1  scratchpad store request, held until st_done
- st_addr  output  32  store base address
- st_matrix  output  4  source matrix register
- st_done  input  1  store finished (single-cycle pulse)
- gemm_valid  output  1  GEMM command valid
- gemm_ready  input  1  GEMM unit accepts command
- gemm_new_weight  output  1  reload weights flag
- gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd  output  4 each  GEMM matrix selects
- mls_complete  output  1  one-cycle pulse: load or store finished
- mls_complete_matrix  output  4  matrix id of completed load/store
- bad_op  output  1  one-cycle pulse: op 2'b00 popped and discarded
- overflow  output  1  sticky: push attempted while full

Behaviour:
- Entry decode:
  - op 2'b01 = LOAD, 2'b10 = STORE, 2'b11 = GEMM, 2'b00 = invalid.
  - LOAD/STORE: matrix = [35:32], addr = [31:0].
  - GEMM: new_weight = [35]; [34:32] and [31:16] ignored; rs1 = [15:12], rs2 = [11:8], rs3 = [7:4], rd = [3:0].
- Reset (async, immediate):
  - FIFO emptied; fifo_count = 0, fifo_full = 0, overflow = 0.
  - All req/valid/pulse outputs 0; all address/matrix/select outputs 0; FSM = IDLE.
  - Reset mid-request abandons the request; done/ready arriving after reset release is ignored while in IDLE.
- FIFO:
  - Circular buffer with read and write pointers; pointers wrap modulo DEPTH.
  - fifo_full = (count == DEPTH), registered from count.
  - Push accepted iff fifo_wen && !fifo_full, including the cycle a pop occurs while full (no same-cycle bypass).
  - fifo_wen while full: data dropped, overflow set and held until RST.
  - Simultaneous push and pop: count unchanged.
  - An entry pushed at edge N is first poppable in the cycle after edge N.
- FSM states IDLE, LOAD, STORE, GEMM:
  - IDLE, count != 0: pop head at the edge; latch fields into output registers; go to LOAD/STORE/GEMM per op.
  - IDLE, op 00: entry discarded, bad_op = 1 for the next cycle, remain IDLE.
  - LOAD: ld_req = 1. On ld_done sampled high: ld_req = 0, mls_complete = 1 with mls_complete_matrix = ld_matrix for the next cycle, go to IDLE.
  - STORE: same as LOAD using st_req/st_done.
  - GEMM: gemm_valid = 1, fields stable. On gemm_ready sampled high: go to IDLE, gemm_valid = 0 next cycle. No mls_complete for GEMM.
  - Stray handshakes: ld_done or st_done outside the matching state is ignored; gemm_ready without gemm_valid is ignored.
- Throughput and latency:
  - Minimum two cycles per request: pop edge, then handshake edge, then back in IDLE.
  - Push-to-request latency with an empty FIFO and IDLE FSM is 2 edges.
- Output stability: address, matrix and select outputs hold their last latched values in IDLE; only req/valid qualify them.
- Request ordering is strictly FIFO; there is no reordering between load, store and GEMM.

Test Plan:
- Reset, then push LOAD 38'h1_3_0000_1000 -> after 2 edges ld_req = 1, ld_addr = 32'h0000_1000, ld_matrix = 3. Assert ld_done -> next cycle mls_complete = 1, mls_complete_matrix = 3, ld_req = 0.
- Push STORE (matrix 5, addr 32'hDEAD_BEE0), then GEMM with new_weight = 1, selects 1/2/3/4 (payload 16'h1234), hold gemm_ready = 0 for 3 cycles -> store completes first. gemm_valid is then held with rs1 = 1, rs2 = 2, rs3 = 3, rd = 4 through the stall; it drops the cycle after gemm_ready.
- Push 9 entries back-to-back while a LOAD stalls on ld_done -> fifo_full after 8 accepted; 9th dropped; overflow = 1 sticky; fifo_count = 8.
- While full, pop and push in the same cycle -> push rejected, count = 7; next-cycle push accepted, count = 8. Pointer wrap is checked by draining 16 entries and verifying order.
- Push op 2'b00 followed by a LOAD -> bad_op pulses exactly one cycle; the LOAD is dispatched next with no mls_complete for the discarded entry.
- Assert RST while st_req is high with 4 entries queued -> all outputs 0 immediately; after release a late st_done yields no mls_complete; fifo_count = 0.
